// File: rtl/writeback_unit_if.sv
// Result bus from the MEM/WB pipeline register into writeback_unit.
// A transfer happens on a rising edge where wb_valid && wb_ready; the master holds addr/data stable while wb_valid is high.
interface writeback_unit_if;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport master (
      output wb_valid,
      output wb_addr,
      output wb_data,
      input  wb_ready
   );

   modport slave (
      input  wb_valid,
      input  wb_addr,
      input  wb_data,
      output wb_ready
   );
endinterface

// File: rtl/writeback_unit.sv
// Buffers retiring results in a DEPTH-entry FIFO and drains one register-file write per cycle.
// Define WB_FORWARD_EN to build the forwarding search; otherwise fwd_hit*/fwd_data* are tied to 0.
module writeback_unit #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       drain_hold,
   writeback_unit_if.slave            wb,
   output logic                       reg_wr,
   output logic [4:0]                 reg_wr_addr,
   output logic [31:0]                reg_wr_data,
   input  logic [4:0]                 fwd_addr1,
   input  logic [4:0]                 fwd_addr2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [31:0]                fwd_data1,
   output logic [31:0]                fwd_data2,
   output logic [$clog2(DEPTH+1)-1:0] pending_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]    addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // r0 writes complete the handshake but never enter the FIFO.
   assign wb.wb_ready   = !rst && (count < CW'(DEPTH));
   assign push          = wb.wb_valid && wb.wb_ready && (wb.wb_addr != 5'd0);
   // drain_hold freezes the drain so the FIFO can be filled; tie low in normal use.
   assign pop           = (count != '0) && !drain_hold;
   assign pending_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= wb.wb_addr;
         data_mem[wr_ptr] <= wb.wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         reg_wr      <= 1'b0;
         reg_wr_addr <= 5'd0;
         reg_wr_data <= 32'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            reg_wr      <= 1'b1;
            reg_wr_addr <= addr_mem[rd_ptr];
            reg_wr_data <= data_mem[rd_ptr];
         end else begin
            reg_wr      <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef WB_FORWARD_EN
   // Oldest-to-youngest scan so the youngest match overwrites; output stage has lowest priority.
   function automatic logic [32:0] lookup(input logic [4:0] a);
      logic [32:0]   r;
      logic [PW-1:0] idx;
      r = 33'd0;
      if (a != 5'd0) begin
         if (reg_wr && (reg_wr_addr == a)) begin
            r = {1'b1, reg_wr_data};
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == a)) begin
               r = {1'b1, data_mem[idx]};
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
      {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
   end
`else
   logic unused_fwd_addr;
   assign unused_fwd_addr = ^{fwd_addr1, fwd_addr2};
   assign fwd_hit1  = 1'b0;
   assign fwd_hit2  = 1'b0;
   assign fwd_data1 = 32'd0;
   assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed checks of writeback_unit against a queue-based reference model.
module tb_writeback_unit;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        drain_hold = 1'b0;
   logic        reg_wr;
   logic [4:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic [4:0]  fwd_addr1 = 5'd0;
   logic [4:0]  fwd_addr2 = 5'd0;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [2:0]  pending_count;

   int vectors = 0;
   int miscompares = 0;

   writeback_unit_if wb_bus ();

   writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .drain_hold    (drain_hold),
      .wb            (wb_bus),
      .reg_wr        (reg_wr),
      .reg_wr_addr   (reg_wr_addr),
      .reg_wr_data   (reg_wr_data),
      .fwd_addr1     (fwd_addr1),
      .fwd_addr2     (fwd_addr2),
      .fwd_hit1      (fwd_hit1),
      .fwd_hit2      (fwd_hit2),
      .fwd_data1     (fwd_data1),
      .fwd_data2     (fwd_data2),
      .pending_count (pending_count)
   );

   always #5 clk = ~clk;

   // Reference model: pending writes in acceptance order, plus the register-file write stage.
   logic [36:0] exp_q[$];
   logic        m_wr   = 1'b0;
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [32:0] model_fwd(input logic [4:0] a);
      logic [32:0] r;
      r = 33'd0;
`ifdef WB_FORWARD_EN
      if (a != 5'd0) begin
         if (m_wr && m_addr == a) r = {1'b1, m_data};
         foreach (exp_q[i]) begin
            if (exp_q[i][36:32] == a) r = {1'b1, exp_q[i][31:0]};
         end
      end
`endif
      return r;
   endfunction

   task automatic compare_outputs();
      logic [32:0] f1, f2;
      f1 = model_fwd(fwd_addr1);
      f2 = model_fwd(fwd_addr2);
      check("wb_ready", {31'd0, wb_bus.wb_ready}, {31'd0, (!rst && exp_q.size() < DEPTH)});
      check("reg_wr", {31'd0, reg_wr}, {31'd0, m_wr});
      check("reg_wr_addr", {27'd0, reg_wr_addr}, {27'd0, m_addr});
      check("reg_wr_data", reg_wr_data, m_data);
      check("pending_count", {29'd0, pending_count}, exp_q.size());
      check("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, f1[32]});
      check("fwd_data1", fwd_data1, f1[31:0]);
      check("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, f2[32]});
      check("fwd_data2", fwd_data2, f2[31:0]);
   endtask

   // One clock: compare on the falling edge, then advance the model at the rising edge.
   task automatic cycle();
      logic accepted;
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      end else begin
         accepted = wb_bus.wb_valid && (exp_q.size() < DEPTH);
         if (exp_q.size() != 0 && !drain_hold) begin
            m_wr = 1'b1;
            {m_addr, m_data} = exp_q.pop_front();
         end else begin
            m_wr = 1'b0;
         end
         if (accepted && wb_bus.wb_addr != 5'd0) exp_q.push_back({wb_bus.wb_addr, wb_bus.wb_data});
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb_bus.wb_valid = v;
      wb_bus.wb_addr  = a;
      wb_bus.wb_data  = d;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      wb_bus.wb_valid = 1'b0;
      wb_bus.wb_addr  = 5'd0;
      wb_bus.wb_data  = 32'd0;
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Single write
      drive(1'b1, 5'd5, 32'hDEADBEEF);
      idle(3);

      // Burst of six back-to-back writes
      for (int i = 1; i <= 6; i++) drive(1'b1, 5'(i), 32'h100 + 32'(i));
      idle(3);

      // r3, r3, r0 with forwarding lookup
      fwd_addr1 = 5'd3;
      fwd_addr2 = 5'd0;
      drive(1'b1, 5'd3, 32'h11);
      drive(1'b1, 5'd3, 32'h22);
      drive(1'b1, 5'd0, 32'h99);
      idle(3);

      // Fill the FIFO with the drain stalled, then release it
      drain_hold = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      fwd_addr1 = 5'd12;
      fwd_addr2 = 5'd14;
      idle(1);
      drain_hold = 1'b0;
      idle(6);

      // Reset with three entries pending
      drain_hold = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
      drain_hold = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(3);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst        = ($urandom_range(0, 99) == 0);
         drain_hold = ($urandom_range(0, 3) == 0);
         fwd_addr1  = 5'($urandom_range(0, 7));
         fwd_addr2  = 5'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      rst = 1'b0;
      drain_hold = 1'b0;
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
